tap_tms_driver: RTL and testbench
=================================

Name: tap_tms_driver

Overview:
- JTAG TMS sequencer: initiator counterpart to the TAP controller, which is the responder.
- Accepts "go to TAP state X" or "reset TAP" commands and drives a registered TMS stream along the shortest path through the IEEE 1149.1 state graph.
- Keeps a shadow copy of the TAP state and checks it against the TAP's 4-bit state observation outputs.
- Sits in the test/route harness, with TMS feeding the TAP's TMS input on the same GCLK.

Parameters:
- CHECK_EN, 1, enables the shadow-vs-observed state comparison
- NAV_CNT_W, 4, width of the navigation cycle counter

Ports:
- GCLK  in  1  clock; the TAP samples TMS on the same rising edge
- TRST  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  driver idle in a stable state; command accepted when valid&&ready
- cmd_reset  in  1  1 = TMS-reset command (5 ones); cmd_target is ignored
- cmd_target  in  4  target TAP state (package encoding)
- tms  out  1  registered TMS to the TAP
- shadow_state  out  4  driver's model of the TAP state
- state_obs  in  4  TAP state observation (state_obs3..0)
- done  out  1  one-cycle pulse when the target is reached
- cmd_err  out  1  one-cycle pulse when the target is rejected
- nav_cycles  out  NAV_CNT_W  TMS edges used by the last command; saturating
- mismatch  out  1  sticky; set when state_obs differs from shadow_state

Behaviour:
- State encoding (IEEE 1149.1):
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Reset (TRST=0, async) sets: shadow_state=F, tms=1, cmd_ready=0 (during reset), done=0, cmd_err=0, nav_cycles=0, mismatch=0, FSM=IDLE.
- Shadow update: on every rising GCLK, shadow_state <= next_state(shadow_state, tms). The value used is the tms presented during that cycle, which matches TAP sampling.
- Stable states are TLR, RTI, ShDR, PauseDR, ShIR and PauseIR. Only these are legal targets.
- A non-stable cmd_target while cmd_ready pulses cmd_err for 1 cycle; no TMS change; the driver stays IDLE.
- FSM states:
  - IDLE: cmd_ready=1. tms is the hold value of the shadow state (1 for TLR, 0 otherwise), so the TAP stays put.
    - On an accepted legal target equal to shadow_state: done pulses the next cycle and nav_cycles=0.
    - On a legal target different from shadow_state: latch the target, go to NAV.
    - On accepted cmd_reset: go to RST.
  - NAV: tms <= tms_toward(next shadow, target) on each edge.
    - Shortest path; ties go to TMS=0.
    - When shadow_state==target: drive the hold value, pulse done, go to IDLE.
    - nav_cycles counts the edges taken and saturates at all-ones.
  - RST: drive tms=1 for exactly 5 edges, then shadow_state=F, pulse done, go to IDLE. Five edges reach TLR from any state.
- Latency: the first path TMS appears the cycle after acceptance. For a target k hops away, done asserts k+1 cycles after acceptance.
- cmd_valid while cmd_ready=0 is ignored (no queueing).
- Check: when CHECK_EN=1 and TRST is high, mismatch <= mismatch | (state_obs != shadow_state) each cycle. It clears only on TRST.
- TRST asserted mid-NAV or mid-RST aborts immediately. There is no done pulse; the driver returns to the reset values.

Decomposition:
- Package tap_pkg:
  - tap_state_t enum with the encoding above
  - is_stable() and hold_tms()
  - next_state(state, tms): the 1149.1 transition function
  - tms_toward(cur, tgt): shortest-path next-hop table
- Sub-module tap_shadow: the shadow-state register plus the mismatch checker. The top holds the command FSM and counters.

Test Plan:
- TRST pulse low, then idle 10 clocks -> shadow_state=F, tms=1 throughout, cmd_ready=1, mismatch=0.
- From TLR, target ShDR(2) -> tms sequence 0,1,0,0; shadow path C,7,6,2; done on the 5th cycle after acceptance; nav_cycles=4.
- From ShDR, target ShIR(A) -> tms 1,1,1,1,0,0 (Ex1DR, UpdDR, SelDR, SelIR, CapIR, ShIR); nav_cycles=6.
- From PauseIR(B), cmd_reset -> 5 ones, shadow=F, done; target UpdDR(5) -> cmd_err pulse, tms stays 1, shadow stays F.
- Mid-NAV to ShIR, assert TRST for 1 cycle -> shadow=F, tms=1, no done. A cmd_valid asserted while busy before the reset -> no effect.
- Force state_obs=C while shadow=F -> mismatch=1 next cycle and stays set until TRST.

Source files
------------

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - IEEE 1149.1 TAP state encoding, transition function and path helpers
package tap_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_NAV  = 2'd1,
        FSM_RST  = 2'd2
    } drv_fsm_t;

    localparam logic [2:0] RST_LAST_EDGE = 3'd4;

    function automatic logic is_stable(tap_state_t s);
        case (s)
            TAP_TLR, TAP_RTI, TAP_SHDR, TAP_PAUSEDR, TAP_SHIR, TAP_PAUSEIR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic hold_tms(tap_state_t s);
        return (s == TAP_TLR);
    endfunction

    function automatic tap_state_t next_state(tap_state_t s, logic tms);
        case (s)
            TAP_TLR:     return tms ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     return tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   return tms ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   return tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    return tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   return tms ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: return tms ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   return tms ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   return tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   return tms ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   return tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    return tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   return tms ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: return tms ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   return tms ? TAP_UPDIR   : TAP_SHIR;
            default:     return tms ? TAP_SELDR   : TAP_RTI;
        endcase
    endfunction

    // Hop count from one state to another, found by growing the reachable set one edge at a time.
    function automatic logic [4:0] tap_dist(tap_state_t from, tap_state_t tgt);
        logic [15:0] reach;
        logic [15:0] grown;
        logic [4:0]  d;
        reach = 16'h0001 << from;
        d     = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (!reach[tgt]) begin
                grown = reach;
                for (int s = 0; s < 16; s++) begin
                    if (reach[s]) begin
                        grown[next_state(tap_state_t'(s[3:0]), 1'b0)] = 1'b1;
                        grown[next_state(tap_state_t'(s[3:0]), 1'b1)] = 1'b1;
                    end
                end
                reach = grown;
                d     = d + 5'd1;
            end
        end
        return d;
    endfunction

    function automatic logic tms_toward(tap_state_t cur, tap_state_t tgt);
        return (tap_dist(next_state(cur, 1'b0), tgt) <= tap_dist(next_state(cur, 1'b1), tgt)) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/tap_shadow.sv
// rtl/tap_shadow.sv - shadow TAP state register and sticky observation mismatch checker
module tap_shadow
    import tap_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    input  logic [3:0] state_obs,
    output logic [3:0] shadow_state,
    output logic [3:0] shadow_next,
    output logic       mismatch
);

    tap_state_t shadow_q, shadow_d;
    logic       mismatch_q, mismatch_d;

    // Advances on the same edge and with the same TMS the TAP itself samples.
    always_comb begin
        shadow_d   = next_state(shadow_q, tms);
        mismatch_d = mismatch_q | (CHECK_EN && (state_obs != shadow_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= TAP_TLR;
            mismatch_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign shadow_state = shadow_q;
    assign shadow_next  = shadow_d;
    assign mismatch     = mismatch_q;

endmodule

// File: rtl/tap_tms_driver.sv
// rtl/tap_tms_driver.sv - JTAG TMS sequencer steering a TAP to a commanded stable state
module tap_tms_driver
    import tap_pkg::*;
#(
    parameter bit CHECK_EN  = 1'b1,
    parameter int NAV_CNT_W = 4
) (
    input  logic                 GCLK,
    input  logic                 TRST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_reset,
    input  logic [3:0]           cmd_target,
    output logic                 tms,
    output logic [3:0]           shadow_state,
    input  logic [3:0]           state_obs,
    output logic                 done,
    output logic                 cmd_err,
    output logic [NAV_CNT_W-1:0] nav_cycles,
    output logic                 mismatch
);

    drv_fsm_t             fsm_q, fsm_d;
    tap_state_t           target_q, target_d;
    logic                 tms_q, tms_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [NAV_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]           rst_cnt_q, rst_cnt_d;
    logic [3:0]           shadow_next_w;
    tap_state_t           shadow_cur, shadow_nxt, cmd_tgt;
    logic                 accept;

    tap_shadow #(
        .CHECK_EN(CHECK_EN)
    ) u_shadow (
        .clk         (GCLK),
        .rst_n       (TRST),
        .tms         (tms_q),
        .state_obs   (state_obs),
        .shadow_state(shadow_state),
        .shadow_next (shadow_next_w),
        .mismatch    (mismatch)
    );

    assign shadow_cur = tap_state_t'(shadow_state);
    assign shadow_nxt = tap_state_t'(shadow_next_w);
    assign cmd_tgt    = tap_state_t'(cmd_target);
    assign cmd_ready  = TRST && (fsm_q == FSM_IDLE);
    assign accept     = cmd_valid && cmd_ready;

    always_comb begin
        fsm_d     = fsm_q;
        target_d  = target_q;
        tms_d     = tms_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        case (fsm_q)
            FSM_IDLE: begin
                tms_d = hold_tms(shadow_nxt);
                if (accept) begin
                    if (cmd_reset) begin
                        fsm_d     = FSM_RST;
                        tms_d     = 1'b1;
                        cnt_d     = '0;
                        rst_cnt_d = 3'd0;
                    end else if (!is_stable(cmd_tgt)) begin
                        err_d = 1'b1;
                    end else if (cmd_tgt == shadow_cur) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        fsm_d    = FSM_NAV;
                        target_d = cmd_tgt;
                        cnt_d    = '0;
                        tms_d    = tms_toward(shadow_nxt, cmd_tgt);
                    end
                end
            end
            FSM_NAV: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (shadow_nxt == target_q) begin
                    tms_d  = hold_tms(shadow_nxt);
                    done_d = 1'b1;
                    fsm_d  = FSM_IDLE;
                end else begin
                    tms_d = tms_toward(shadow_nxt, target_q);
                end
            end
            FSM_RST: begin
                cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                rst_cnt_d = rst_cnt_q + 3'd1;
                tms_d     = 1'b1;
                if (rst_cnt_q == RST_LAST_EDGE) begin
                    tms_d  = hold_tms(shadow_nxt);
                    done_d = 1'b1;
                    fsm_d  = FSM_IDLE;
                end
            end
            default: begin
                fsm_d = FSM_IDLE;
                tms_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge GCLK or negedge TRST) begin
        if (!TRST) begin
            fsm_q     <= FSM_IDLE;
            target_q  <= TAP_TLR;
            tms_q     <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rst_cnt_q <= 3'd0;
        end else begin
            fsm_q     <= fsm_d;
            target_q  <= target_d;
            tms_q     <= tms_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign tms        = tms_q;
    assign done       = done_q;
    assign cmd_err    = err_q;
    assign nav_cycles = cnt_q;

endmodule

// File: tb/tb_tap_tms_driver.sv
// tb/tb_tap_tms_driver.sv - directed self-checking bench for tap_tms_driver
module tb_tap_tms_driver;

    logic       GCLK = 1'b0;
    logic       TRST = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_reset = 1'b0;
    logic [3:0] cmd_target = 4'h0;
    logic       tms;
    logic [3:0] shadow_state;
    logic [3:0] state_obs;
    logic       done;
    logic       cmd_err;
    logic [3:0] nav_cycles;
    logic       mismatch;
    logic       obs_force = 1'b0;
    logic [3:0] obs_val = 4'h0;

    int checks = 0;
    int errors = 0;

    // A well-behaved TAP reports the state the driver believes in, unless overridden.
    assign state_obs = obs_force ? obs_val : shadow_state;

    always #5 GCLK = ~GCLK;

    tap_tms_driver #(
        .CHECK_EN (1'b1),
        .NAV_CNT_W(4)
    ) dut (
        .GCLK        (GCLK),
        .TRST        (TRST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_reset   (cmd_reset),
        .cmd_target  (cmd_target),
        .tms         (tms),
        .shadow_state(shadow_state),
        .state_obs   (state_obs),
        .done        (done),
        .cmd_err     (cmd_err),
        .nav_cycles  (nav_cycles),
        .mismatch    (mismatch)
    );

    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    task automatic issue(input logic rst, input logic [3:0] tgt);
        cmd_valid  = 1'b1;
        cmd_reset  = rst;
        cmd_target = tgt;
        tick();
        cmd_valid  = 1'b0;
        cmd_reset  = 1'b0;
    endtask

    task automatic test_reset();
        TRST = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b exp 0", cmd_ready); end
        checks++; if (shadow_state !== 4'hF) begin errors++; $display("FAIL rst_shadow: got %h exp F", shadow_state); end
        checks++; if ({tms, done, cmd_err, mismatch, nav_cycles} !== 8'b1000_0000) begin errors++; $display("FAIL rst_outputs: got %b exp 10000000", {tms, done, cmd_err, mismatch, nav_cycles}); end
        TRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({shadow_state, tms, cmd_ready, mismatch, done} !== 8'b1111_1100) begin errors++; $display("FAIL rst_idle cyc%0d: got %b exp 11111100", i, {shadow_state, tms, cmd_ready, mismatch, done}); end
        end
    endtask

    task automatic test_tlr_to_shdr();
        logic       e_tms [4];
        logic [3:0] e_sh  [4];
        e_tms = '{1'b0, 1'b1, 1'b0, 1'b0};
        e_sh  = '{4'hF, 4'hC, 4'h7, 4'h6};
        issue(1'b0, 4'h2);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({tms, shadow_state, done, cmd_ready} !== {e_tms[i], e_sh[i], 2'b00}) begin errors++; $display("FAIL shdr_path cyc%0d: got tms=%b sh=%h done=%b rdy=%b exp tms=%b sh=%h done=0 rdy=0", i + 1, tms, shadow_state, done, cmd_ready, e_tms[i], e_sh[i]); end
            tick();
        end
        checks++; if ({done, shadow_state, tms, cmd_ready} !== {1'b1, 4'h2, 1'b0, 1'b1}) begin errors++; $display("FAIL shdr_done: got done=%b sh=%h tms=%b rdy=%b exp 1 2 0 1", done, shadow_state, tms, cmd_ready); end
        checks++; if (nav_cycles !== 4'd4) begin errors++; $display("FAIL shdr_nav_cycles: got %0d exp 4", nav_cycles); end
        tick();
        checks++; if ({done, shadow_state} !== {1'b0, 4'h2}) begin errors++; $display("FAIL shdr_settle: got done=%b sh=%h exp 0 2", done, shadow_state); end
    endtask

    task automatic test_shdr_to_shir();
        logic       e_tms [6];
        logic [3:0] e_sh  [6];
        e_tms = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        e_sh  = '{4'h2, 4'h1, 4'h5, 4'h7, 4'h4, 4'hE};
        issue(1'b0, 4'hA);
        for (int i = 0; i < 6; i++) begin
            checks++; if ({tms, shadow_state, done} !== {e_tms[i], e_sh[i], 1'b0}) begin errors++; $display("FAIL shir_path cyc%0d: got tms=%b sh=%h done=%b exp tms=%b sh=%h done=0", i + 1, tms, shadow_state, done, e_tms[i], e_sh[i]); end
            tick();
        end
        checks++; if ({done, shadow_state, nav_cycles} !== {1'b1, 4'hA, 4'd6}) begin errors++; $display("FAIL shir_done: got done=%b sh=%h nav=%0d exp 1 A 6", done, shadow_state, nav_cycles); end
    endtask

    task automatic test_reset_cmd();
        logic [3:0] e_sh [5];
        e_sh = '{4'hB, 4'h8, 4'hD, 4'h7, 4'h4};
        tick();
        issue(1'b0, 4'hB);
        checks++; if ({tms, shadow_state} !== {1'b1, 4'hA}) begin errors++; $display("FAIL pir_c1: got tms=%b sh=%h exp 1 A", tms, shadow_state); end
        tick();
        checks++; if ({tms, shadow_state} !== {1'b0, 4'h9}) begin errors++; $display("FAIL pir_c2: got tms=%b sh=%h exp 0 9", tms, shadow_state); end
        tick();
        checks++; if ({done, shadow_state, nav_cycles} !== {1'b1, 4'hB, 4'd2}) begin errors++; $display("FAIL pir_done: got done=%b sh=%h nav=%0d exp 1 B 2", done, shadow_state, nav_cycles); end
        tick();
        issue(1'b1, 4'h2);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({tms, shadow_state, done, cmd_ready} !== {1'b1, e_sh[i], 2'b00}) begin errors++; $display("FAIL rstcmd cyc%0d: got tms=%b sh=%h done=%b rdy=%b exp tms=1 sh=%h done=0 rdy=0", i + 1, tms, shadow_state, done, cmd_ready, e_sh[i]); end
            tick();
        end
        checks++; if ({done, shadow_state, tms, nav_cycles} !== {1'b1, 4'hF, 1'b1, 4'd5}) begin errors++; $display("FAIL rstcmd_done: got done=%b sh=%h tms=%b nav=%0d exp 1 F 1 5", done, shadow_state, tms, nav_cycles); end
        tick();
        issue(1'b0, 4'h5);
        checks++; if ({cmd_err, done, tms, shadow_state, cmd_ready} !== {3'b101, 4'hF, 1'b1}) begin errors++; $display("FAIL err_pulse: got err=%b done=%b tms=%b sh=%h rdy=%b exp 1 0 1 F 1", cmd_err, done, tms, shadow_state, cmd_ready); end
        tick();
        checks++; if ({cmd_err, tms, shadow_state} !== {2'b01, 4'hF}) begin errors++; $display("FAIL err_clear: got err=%b tms=%b sh=%h exp 0 1 F", cmd_err, tms, shadow_state); end
        issue(1'b0, 4'hF);
        checks++; if ({done, nav_cycles, shadow_state, tms} !== {1'b1, 4'd0, 4'hF, 1'b1}) begin errors++; $display("FAIL same_target: got done=%b nav=%0d sh=%h tms=%b exp 1 0 F 1", done, nav_cycles, shadow_state, tms); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL same_target_pulse: got %b exp 0", done); end
    endtask

    task automatic test_abort();
        issue(1'b0, 4'hA);
        checks++; if ({tms, shadow_state} !== {1'b0, 4'hF}) begin errors++; $display("FAIL abort_c1: got tms=%b sh=%h exp 0 F", tms, shadow_state); end
        cmd_valid = 1'b1;
        cmd_reset = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_reset = 1'b0;
        checks++; if ({tms, shadow_state, cmd_ready} !== {1'b1, 4'hC, 1'b0}) begin errors++; $display("FAIL busy_ignored: got tms=%b sh=%h rdy=%b exp 1 C 0", tms, shadow_state, cmd_ready); end
        tick();
        checks++; if ({tms, shadow_state} !== {1'b1, 4'h7}) begin errors++; $display("FAIL abort_c3: got tms=%b sh=%h exp 1 7", tms, shadow_state); end
        TRST = 1'b0;
        #1;
        checks++; if ({shadow_state, tms, cmd_ready, done, nav_cycles} !== {4'hF, 3'b100, 4'd0}) begin errors++; $display("FAIL abort_async: got sh=%h tms=%b rdy=%b done=%b nav=%0d exp F 1 0 0 0", shadow_state, tms, cmd_ready, done, nav_cycles); end
        tick();
        TRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({shadow_state, tms, done, cmd_ready} !== {4'hF, 3'b101}) begin errors++; $display("FAIL abort_after cyc%0d: got sh=%h tms=%b done=%b rdy=%b exp F 1 0 1", i, shadow_state, tms, done, cmd_ready); end
        end
    endtask

    task automatic test_mismatch();
        obs_force = 1'b1;
        obs_val   = 4'hC;
        #1;
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_before: got %b exp 0", mismatch); end
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_set: got %b exp 1", mismatch); end
        obs_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky cyc%0d: got %b exp 1", i, mismatch); end
        end
        TRST = 1'b0;
        tick();
        TRST = 1'b1;
        tick();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_cleared: got %b exp 0", mismatch); end
    endtask

    initial begin
        test_reset();
        test_tlr_to_shdr();
        test_shdr_to_shir();
        test_reset_cmd();
        test_abort();
        test_mismatch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
